int_rti_sequencer: RTL

Multi-cycle sequencer for interrupt entry and RTI exit in the 16-bit RISC pipeline. It sits beside the decode stage, freezes fetch/decode while active, and drives the stack and PC/CCR load paths. On interrupt it pushes the resume PC and the CCR, reads the ISR vector, and redirects fetch. On RTI it pops CCR and PC in reverse order and resumes.

---
 rtl/int_rti_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/int_rti_sequencer.sv
// Interrupt-entry / RTI-exit sequencer for the 16-bit RISC pipeline.
// Freezes the front end while it stacks or unstacks PC and CCR, then redirects fetch.
module int_rti_sequencer #(
   parameter logic [15:0] VEC_ADDR = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        interrupt,
   input  logic        rti_dec,
   input  logic        pipe_busy,
   input  logic [31:0] pc_cur,
   input  logic [2:0]  ccr,
   input  logic        mem_ready,
   input  logic [15:0] mem_rdata,
   output logic        freeze,
   output logic        flush,
   output logic        stack_push,
   output logic        stack_pop,
   output logic [15:0] mem_wdata,
   output logic        vec_rd,
   output logic [15:0] vec_addr,
   output logic        pc_load,
   output logic [31:0] pc_next,
   output logic        ccr_load,
   output logic [2:0]  ccr_next,
   output logic        int_ack,
   output logic        busy
);

   typedef enum logic [3:0] {
      IDLE, I_FLUSH, I_PUSH_PCH, I_PUSH_PCL, I_PUSH_CCR, I_VEC_L, I_VEC_H, I_LOAD,
      R_POP_CCR, R_POP_PCL, R_POP_PCH, R_LOAD
   } state_t;

   state_t      state_q, state_d;
   logic        pending_q, pending_d;
   logic [31:0] pc_save_q, pc_save_d;
   logic [2:0]  ccr_save_q, ccr_save_d;
   logic [15:0] vec_lo_q, vec_lo_d;
   logic [15:0] vec_hi_q, vec_hi_d;
   logic [15:0] pc_lo_q, pc_lo_d;
   logic [15:0] pc_hi_q, pc_hi_d;
   logic [2:0]  ccr_hold_q, ccr_hold_d;
   logic        accept;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      state_d    = state_q;
      pending_d  = pending_q | interrupt;
      pc_save_d  = pc_save_q;
      ccr_save_d = ccr_save_q;
      vec_lo_d   = vec_lo_q;
      vec_hi_d   = vec_hi_q;
      pc_lo_d    = pc_lo_q;
      pc_hi_d    = pc_hi_q;
      ccr_hold_d = ccr_hold_q;
      accept     = 1'b0;

      case (state_q)
         IDLE: begin
            // Interrupt beats a same-cycle RTI; pc_cur points at the RTI so it re-executes later.
            if ((interrupt || pending_q) && !pipe_busy) begin
               accept     = 1'b1;
               state_d    = I_FLUSH;
               pc_save_d  = pc_cur;
               ccr_save_d = ccr;
            end else if (rti_dec) begin
               state_d = R_POP_CCR;
            end
         end
         I_FLUSH:    state_d = I_PUSH_PCH;
         I_PUSH_PCH: if (mem_ready) state_d = I_PUSH_PCL;
         I_PUSH_PCL: if (mem_ready) state_d = I_PUSH_CCR;
         I_PUSH_CCR: if (mem_ready) state_d = I_VEC_L;
         I_VEC_L: if (mem_ready) begin
            vec_lo_d = mem_rdata;
            state_d  = I_VEC_H;
         end
         I_VEC_H: if (mem_ready) begin
            vec_hi_d = mem_rdata;
            state_d  = I_LOAD;
         end
         I_LOAD: state_d = IDLE;
         R_POP_CCR: if (mem_ready) begin
            ccr_hold_d = mem_rdata[2:0];
            state_d    = R_POP_PCL;
         end
         R_POP_PCL: if (mem_ready) begin
            pc_lo_d = mem_rdata;
            state_d = R_POP_PCH;
         end
         R_POP_PCH: if (mem_ready) begin
            pc_hi_d = mem_rdata;
            state_d = R_LOAD;
         end
         R_LOAD:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (accept) pending_d = 1'b0;
   end

   // Moore outputs: decoded from the registered state and capture registers only.
   always_comb begin
      freeze     = (state_q != IDLE);
      busy       = (state_q != IDLE);
      flush      = 1'b0;
      stack_push = 1'b0;
      stack_pop  = 1'b0;
      mem_wdata  = 16'h0000;
      vec_rd     = 1'b0;
      vec_addr   = 16'h0000;
      pc_load    = 1'b0;
      pc_next    = 32'h0000_0000;
      ccr_load   = 1'b0;
      ccr_next   = 3'b000;
      int_ack    = 1'b0;

      case (state_q)
         I_FLUSH: flush = 1'b1;
         I_PUSH_PCH: begin
            stack_push = 1'b1;
            mem_wdata  = pc_save_q[31:16];
         end
         I_PUSH_PCL: begin
            stack_push = 1'b1;
            mem_wdata  = pc_save_q[15:0];
         end
         I_PUSH_CCR: begin
            stack_push = 1'b1;
            mem_wdata  = {13'b0, ccr_save_q};
         end
         I_VEC_L: begin
            vec_rd   = 1'b1;
            vec_addr = VEC_ADDR;
         end
         I_VEC_H: begin
            vec_rd   = 1'b1;
            vec_addr = VEC_ADDR + 16'd1;
         end
         I_LOAD: begin
            pc_load = 1'b1;
            pc_next = {vec_hi_q, vec_lo_q};
            int_ack = 1'b1;
         end
         R_POP_CCR, R_POP_PCL, R_POP_PCH: stack_pop = 1'b1;
         R_LOAD: begin
            pc_load  = 1'b1;
            ccr_load = 1'b1;
            flush    = 1'b1;
            pc_next  = {pc_hi_q, pc_lo_q};
            ccr_next = ccr_hold_q;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         pending_q  <= 1'b0;
         pc_save_q  <= 32'h0000_0000;
         ccr_save_q <= 3'b000;
         vec_lo_q   <= 16'h0000;
         vec_hi_q   <= 16'h0000;
         pc_lo_q    <= 16'h0000;
         pc_hi_q    <= 16'h0000;
         ccr_hold_q <= 3'b000;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         pc_save_q  <= pc_save_d;
         ccr_save_q <= ccr_save_d;
         vec_lo_q   <= vec_lo_d;
         vec_hi_q   <= vec_hi_d;
         pc_lo_q    <= pc_lo_d;
         pc_hi_q    <= pc_hi_d;
         ccr_hold_q <= ccr_hold_d;
      end
   end

endmodule
